fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage feeding the single-cycle datapath: holds the program counter, issues word reads to instruction memory over a request/grant/response interface, and buffers returned words in a small in-order queue. The datapath consumes one `instr` word per accepted handshake and redirects fetch on a taken branch (`TRZF & branch`). The block replaces the free-running `PC` and `Adder` pair with a stall- and variable-latency-tolerant front end.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- `DEPTH`, 2, instruction queue entries; minimum 2.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: read request valid.
- `imem_addr` out 32: byte address of the requested word; [1:0] always 0.
- `imem_gnt` in 1: request accepted this cycle when `imem_req & imem_gnt`.
- `imem_rvalid` in 1: response valid; earliest one cycle after grant.
- `imem_rdata` in 32: instruction word, valid with `imem_rvalid`.
- `instr_valid` out 1: queue head valid.
- `instr_ready` in 1: datapath accepts head; pop = `instr_valid & instr_ready`.
- `instr` out 32: head instruction word.
- `instr_pc` out 32: address of head word.
- `instr_pc4` out 32: `instr_pc + 4`, modulo 2^32.
- `redirect` in 1: taken branch this cycle.
- `redirect_pc` in 32: new fetch address; bits [1:0] ignored (forced 0).
- `proto_err` out 1: sticky, set on `imem_rvalid` with no request in flight.

## Operation
- Registers: `fetch_pc` (next address to request), queue of {pc, word}, occupancy `occ`, request state.
- States: IDLE (nothing in flight), WAIT (one granted request in flight), DROP (one in flight, response to be discarded). At most one outstanding request.
- Issue condition: `!rst & !redirect & (IDLE | (WAIT & imem_rvalid) | (DROP & imem_rvalid)) & (occ + inflight − pop < DEPTH)`, where `inflight` = 1 in WAIT, 0 otherwise. `imem_req` is driven exactly when this holds; `imem_addr = fetch_pc`.
- On grant: state -> WAIT, tag request with `fetch_pc`, `fetch_pc <= fetch_pc + 4` (wraps at 2^32).
- `imem_req` high without grant: `imem_addr` held stable next cycle unless `redirect`; an ungranted request may be withdrawn.
- WAIT & `imem_rvalid`: push {tag, `imem_rdata`}; state -> IDLE, or WAIT on a same-cycle new grant.
- DROP & `imem_rvalid`: data discarded; state -> IDLE, or WAIT on a new grant.
- IDLE & `imem_rvalid`: ignored; `proto_err <= 1`.
- `redirect`: queue flushed (`occ <= 0`); `fetch_pc <= {redirect_pc[31:2],2'b00}`; WAIT -> DROP; no request issued this cycle. A pop in the same cycle completes normally. A response arriving the same cycle is discarded.
- Queue: FIFO, in order, never overflows (guaranteed by the issue condition); push and pop in the same cycle allowed at any occupancy.

## Timing
- Reset (`rst` high at an edge): `fetch_pc = RESET_PC`, `occ = 0`, state IDLE, `proto_err = 0`. During any cycle with `rst` high: `imem_req = 0` and `instr_valid = 0`, and `imem_rvalid` is ignored. Instruction memory is reset by the same `rst`; responses to pre-reset requests never arrive.
- Reset mid-operation discards queue and in-flight request; no stale word appears afterwards.
- Zero-wait memory (`gnt` = 1, `rvalid` next cycle): first request in the cycle after reset release (C0); `instr_valid` at C2; sustained 1 instruction/cycle with `DEPTH` = 2 and `instr_ready` held high.
- Redirect at cycle R: first request to the target at R+1; target instruction valid at R+3 with zero-wait memory.
- Outputs `instr`, `instr_pc`, `instr_pc4`, `instr_valid` are registered queue-head values; `imem_req` and `imem_addr` are combinational from state, `occ`, `rvalid`, `redirect`, `instr_ready`.

## Test plan
- Reset/stream: `RESET_PC` = 0, zero-wait memory returning `0xA500_0000 | addr` -> `imem_addr` 0, 4, 8, … on consecutive cycles; `instr_valid` from C2 with `instr_pc` 0, 4, 8, `instr_pc4` 4, 8, C.
- Backpressure: `instr_ready` = 0 for 6 cycles mid-stream -> `occ` saturates at 2, `imem_req` low, then resumes; no word lost, duplicated or reordered.
- Redirect with request in flight (memory latency 3): `redirect` to 0x40 while word 0x10 is outstanding -> 0x10 never presented, next `imem_addr` = 0x40, next `instr_pc` = 0x40.
- Redirect coincident with `imem_rvalid` and a pop -> popped word delivered once, returning word dropped, queue empty, `redirect_pc` = 0x43 fetched as 0x40.
- Wrap: `RESET_PC` = 0xFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; `instr_pc4` of FFFF_FFFC = 0.
- Protocol: `imem_gnt` held low 4 cycles -> `imem_addr` stable; spurious `imem_rvalid` in IDLE -> `proto_err` = 1 and stays 1 until `rst`; queue unchanged.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: program counter, single-outstanding
// instruction-memory request FSM and a small in-order instruction queue.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        proto_err
);

    localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   OW      = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [OW:0]   DEPTH_W = (OW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_e;

    state_e        state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_pc_d;
    logic [31:0]   tag_q;
    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic          proto_err_q;
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   word_mem_q [DEPTH];

    logic          inflight;
    logic          push;
    logic          pop;
    logic          grant;
    logic [OW:0]   need;
    logic [OW:0]   room;
    logic          unused_rpc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign unused_rpc  = ^redirect_pc[1:0];

    assign inflight    = (state_q == WAIT);
    assign instr_valid = !rst && (occ_q != '0);
    assign pop         = instr_valid && instr_ready;

    // Slots still free once the in-flight word lands and this cycle's pop leaves.
    assign need        = {1'b0, occ_q} + (OW+1)'(inflight);
    assign room        = DEPTH_W + (OW+1)'(pop);

    assign imem_req    = !rst && !redirect
                       && (state_q == IDLE || imem_rvalid)
                       && (need < room);
    assign imem_addr   = fetch_pc_q;
    assign grant       = imem_req && imem_gnt;
    assign push        = !rst && !redirect && inflight && imem_rvalid;

    assign instr       = word_mem_q[rd_q];
    assign instr_pc    = pc_mem_q[rd_q];
    assign instr_pc4   = pc_mem_q[rd_q] + 32'd4;
    assign proto_err   = proto_err_q;

    always_comb begin
        occ_d      = occ_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            occ_d      = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else begin
            occ_d = occ_q + OW'(push) - OW'(pop);
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            tag_q       <= RESET_PC;
            occ_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            proto_err_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            occ_q      <= occ_d;
            if (state_q == IDLE && imem_rvalid) begin
                proto_err_q <= 1'b1;
            end
            if (grant) begin
                tag_q <= fetch_pc_q;
            end
            if (redirect) begin
                rd_q <= '0;
                wr_q <= '0;
            end else begin
                if (push) wr_q <= ptr_inc(wr_q);
                if (pop)  rd_q <= ptr_inc(rd_q);
            end
            // A redirect never coincides with a grant; a same-cycle
            // response retires the old request, otherwise it is dropped later.
            unique case (state_q)
                IDLE: begin
                    if (grant) state_q <= WAIT;
                end
                WAIT, DROP: begin
                    if (grant)            state_q <= WAIT;
                    else if (imem_rvalid) state_q <= IDLE;
                    else if (redirect)    state_q <= DROP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_q]   <= tag_q;
            word_mem_q[wr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: behavioural instruction memory with
// configurable latency, expected words queued on response, checked on pop.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        a_req, a_valid, a_perr;
    logic [31:0] a_addr, a_instr, a_pc, a_pc4;
    logic        w_req, w_valid, w_perr;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;

    logic        sel;
    logic        m_req, m_valid, m_perr;
    logic [31:0] m_addr, m_instr, m_pc, m_pc4;

    localparam logic [31:0] W_RST = 32'hFFFF_FFF8;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(a_req), .imem_addr(a_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(a_valid), .instr_ready(instr_ready),
        .instr(a_instr), .instr_pc(a_pc), .instr_pc4(a_pc4),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .proto_err(a_perr)
    );

    fetch_unit #(.RESET_PC(W_RST), .DEPTH(2)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(w_valid), .instr_ready(instr_ready),
        .instr(w_instr), .instr_pc(w_pc), .instr_pc4(w_pc4),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .proto_err(w_perr)
    );

    assign m_req   = sel ? w_req   : a_req;
    assign m_valid = sel ? w_valid : a_valid;
    assign m_perr  = sel ? w_perr  : a_perr;
    assign m_addr  = sel ? w_addr  : a_addr;
    assign m_instr = sel ? w_instr : a_instr;
    assign m_pc    = sel ? w_pc    : a_pc;
    assign m_pc4   = sel ? w_pc4   : a_pc4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          npops  = 0;
    int          lat    = 1;
    int          gnt_off;
    logic        spur;

    logic        mem_busy = 1'b0;
    logic        mem_live = 1'b0;
    int          mem_rem  = 0;
    logic [31:0] mem_addr = '0;
    logic [31:0] exp_addr = '0;
    logic        exp_perr = 1'b0;

    logic        last_req, last_valid, last_gnt, last_pop;
    logic [31:0] last_addr, last_gaddr, last_pop_pc, last_pop_pc4;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    task automatic cyc();
        logic resp;
        exp_t e;
        resp        = mem_busy && (mem_rem == 0) && !rst;
        imem_rvalid = resp || spur;
        imem_rdata  = resp ? (32'hA500_0000 | mem_addr) : 32'hDEAD_BEEF;
        imem_gnt    = (gnt_off == 0);
        #1;
        last_req   = m_req;
        last_addr  = m_addr;
        last_valid = m_valid;
        last_gnt   = 1'b0;
        last_pop   = 1'b0;
        if (rst) begin
            check("rst_req", m_req, 0);
            check("rst_valid", m_valid, 0);
            exp_q.delete();
            mem_busy = 1'b0;
            exp_perr = 1'b0;
            exp_addr = sel ? W_RST : 32'h0;
        end else begin
            check("perr", m_perr, exp_perr);
            check("valid", m_valid, exp_q.size() != 0);
            if (m_valid && instr_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("instr", m_instr, e.word);
                check("pc", m_pc, e.pc);
                check("pc4", m_pc4, e.pc + 32'd4);
                last_pop     = 1'b1;
                last_pop_pc  = m_pc;
                last_pop_pc4 = m_pc4;
                npops++;
            end
            if (resp && mem_live && !redirect)
                exp_q.push_back('{pc: mem_addr, word: 32'hA500_0000 | mem_addr});
            if (spur && !mem_busy) exp_perr = 1'b1;
            if (resp) mem_busy = 1'b0;
            else if (mem_busy) mem_rem--;
            if (m_req) check("addr", m_addr, exp_addr);
            if (m_req && imem_gnt) begin
                mem_busy   = 1'b1;
                mem_rem    = lat - 1;
                mem_addr   = m_addr;
                mem_live   = 1'b1;
                exp_addr   = exp_addr + 32'd4;
                last_gnt   = 1'b1;
                last_gaddr = m_addr;
            end
            if (redirect) begin
                check("redir_req", m_req, 0);
                exp_q.delete();
                mem_live = 1'b0;
                exp_addr = redirect_pc & 32'hFFFF_FFFC;
            end
        end
        if (gnt_off != 0) gnt_off--;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic s);
        sel      = s;
        rst      = 1'b1;
        redirect = 1'b0;
        spur     = 1'b0;
        gnt_off  = 0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   first_v;
        int   n0;
        logic found;
        rst         = 1'b1;
        sel         = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        spur        = 1'b0;
        gnt_off     = 0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        #2;

        // reset and zero-wait stream
        lat = 1;
        do_reset(1'b0);
        first_v = -1;
        n0 = npops;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (i == 0) begin
                check("c0_req", last_req, 1);
                check("c0_addr", last_addr, 0);
            end
            if (first_v < 0 && last_valid) first_v = i;
        end
        check("c2_valid", first_v, 2);
        check("stream_rate", npops - n0, 10);

        // backpressure
        instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i > 0) check("bp_req", last_req, 0);
            check("bp_hold", last_valid, 1);
        end
        instr_ready = 1'b1;
        n0 = npops;
        for (int i = 0; i < 8; i++) cyc();
        check("bp_resume", npops - n0, 8);

        // redirect while 0x10 is outstanding, latency 3
        lat = 3;
        do_reset(1'b0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc();
            if (last_gnt && last_gaddr == 32'h10) found = 1'b1;
        end
        check("find_10", found, 1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        cyc();
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (last_gnt) found = 1'b1;
        end
        check("rd_gaddr", last_gaddr, 32'h40);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (last_pop) found = 1'b1;
        end
        check("rd_first_pc", last_pop_pc, 32'h40);

        // redirect coincident with response and pop, unaligned target
        lat = 1;
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        n0 = npops;
        cyc();
        redirect = 1'b0;
        check("rc_pop", npops - n0, 1);
        cyc();
        check("rc_r1_req", last_req, 1);
        check("rc_r1_addr", last_addr, 32'h40);
        check("rc_r1_valid", last_valid, 0);
        cyc();
        check("rc_r2_valid", last_valid, 0);
        cyc();
        check("rc_r3_valid", last_valid, 1);
        check("rc_r3_pc", last_pop_pc, 32'h40);
        for (int i = 0; i < 4; i++) cyc();

        // address wrap
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i < 3) begin
                check("wrap_gnt", last_gnt, 1);
                check("wrap_addr", last_gaddr, W_RST + 32'(4 * i));
            end
            if (last_pop && last_pop_pc == 32'hFFFF_FFFC)
                check("wrap_pc4", last_pop_pc4, 32'h0);
        end
        sel = 1'b0;

        // grant stall and spurious response
        do_reset(1'b0);
        gnt_off = 4;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("ng_req", last_req, 1);
            check("ng_addr", last_addr, 32'h0);
        end
        instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        check("spur_idle", mem_busy, 0);
        spur = 1'b1;
        cyc();
        spur = 1'b0;
        check("perr_set", m_perr, 1);
        for (int i = 0; i < 3; i++) cyc();
        check("perr_sticky", m_perr, 1);
        instr_ready = 1'b1;
        n0 = npops;
        for (int i = 0; i < 6; i++) cyc();
        check("spur_resume", npops - n0, 6);
        do_reset(1'b0);
        check("perr_clr", m_perr, 0);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
